// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: supported widths, XAPP052 tap masks and the single-step function.
// All helpers work on 64-bit vectors so one function serves every supported width.
package lfsr_pkg;

    localparam int LFSR_MIN_BITS  = 3;
    localparam int LFSR_MAX_BITS  = 32;
    localparam int LFSR_WIDE_BITS = 64;

    typedef struct packed {
        logic [63:0] state;
        logic        fb;
    } lfsr_step_t;

    function automatic bit lfsr_supported(input int n);
        return ((n >= LFSR_MIN_BITS) && (n <= LFSR_MAX_BITS)) || (n == LFSR_WIDE_BITS);
    endfunction

    // Tap t (1-based, as in the XAPP052 table) sits at bit t-1.
    function automatic logic [63:0] lfsr_tap(input int t);
        return 64'd1 << (t - 1);
    endfunction

    function automatic logic [63:0] lfsr_taps(input int n);
        logic [63:0] m;
        m = '0;
        case (n)
            3:  m = lfsr_tap(3)  | lfsr_tap(2);
            4:  m = lfsr_tap(4)  | lfsr_tap(3);
            5:  m = lfsr_tap(5)  | lfsr_tap(3);
            6:  m = lfsr_tap(6)  | lfsr_tap(5);
            7:  m = lfsr_tap(7)  | lfsr_tap(6);
            8:  m = lfsr_tap(8)  | lfsr_tap(6)  | lfsr_tap(5) | lfsr_tap(4);
            9:  m = lfsr_tap(9)  | lfsr_tap(5);
            10: m = lfsr_tap(10) | lfsr_tap(7);
            11: m = lfsr_tap(11) | lfsr_tap(9);
            12: m = lfsr_tap(12) | lfsr_tap(6)  | lfsr_tap(4) | lfsr_tap(1);
            13: m = lfsr_tap(13) | lfsr_tap(4)  | lfsr_tap(3) | lfsr_tap(1);
            14: m = lfsr_tap(14) | lfsr_tap(5)  | lfsr_tap(3) | lfsr_tap(1);
            15: m = lfsr_tap(15) | lfsr_tap(14);
            16: m = lfsr_tap(16) | lfsr_tap(15) | lfsr_tap(13) | lfsr_tap(4);
            17: m = lfsr_tap(17) | lfsr_tap(14);
            18: m = lfsr_tap(18) | lfsr_tap(11);
            19: m = lfsr_tap(19) | lfsr_tap(6)  | lfsr_tap(2) | lfsr_tap(1);
            20: m = lfsr_tap(20) | lfsr_tap(17);
            21: m = lfsr_tap(21) | lfsr_tap(19);
            22: m = lfsr_tap(22) | lfsr_tap(21);
            23: m = lfsr_tap(23) | lfsr_tap(18);
            24: m = lfsr_tap(24) | lfsr_tap(23) | lfsr_tap(22) | lfsr_tap(17);
            25: m = lfsr_tap(25) | lfsr_tap(22);
            26: m = lfsr_tap(26) | lfsr_tap(6)  | lfsr_tap(2) | lfsr_tap(1);
            27: m = lfsr_tap(27) | lfsr_tap(5)  | lfsr_tap(2) | lfsr_tap(1);
            28: m = lfsr_tap(28) | lfsr_tap(25);
            29: m = lfsr_tap(29) | lfsr_tap(27);
            30: m = lfsr_tap(30) | lfsr_tap(6)  | lfsr_tap(4) | lfsr_tap(1);
            31: m = lfsr_tap(31) | lfsr_tap(28);
            32: m = lfsr_tap(32) | lfsr_tap(22) | lfsr_tap(2) | lfsr_tap(1);
            64: m = lfsr_tap(64) | lfsr_tap(63) | lfsr_tap(61) | lfsr_tap(60);
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] lfsr_ones(input int n);
        return ~64'd0 >> (64 - n);
    endfunction

    // Every tap set has an even tap count, so the XNOR chain reduces to inverted parity.
    function automatic lfsr_step_t lfsr_step(input logic [63:0] s, input int n);
        lfsr_step_t r;
        r.fb    = ~^(s & lfsr_taps(n));
        r.state = ((s << 1) | 64'(r.fb)) & lfsr_ones(n);
        return r;
    endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Valid/ready word stream leaving the LFSR generator.
interface lfsr_stream_if #(
    parameter int STEP = 8
);
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [STEP-1:0] OUT_WORD;

    modport master (output OUT_VALID, output OUT_WORD, input OUT_READY);
    modport slave  (input OUT_VALID, input OUT_WORD, output OUT_READY);
endinterface

// File: rtl/lfsr_leap.sv
// Combinational STEP-fold LFSR advance; the first generated bit lands in the word MSB.
module lfsr_leap
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 32,
    parameter int STEP     = 8
) (
    input  logic [NUM_BITS-1:0] state,
    output logic [NUM_BITS-1:0] next_state,
    output logic [STEP-1:0]     word
);

    logic [63:0] s;
    lfsr_step_t  st;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch behind.
        s    = 64'(state);
        st   = '0;
        word = '0;
        for (int k = 0; k < STEP; k++) begin
            st                = lfsr_step(s, NUM_BITS);
            word[STEP - 1 - k] = st.fb;
            s                 = st.state;
        end
        next_state = s[NUM_BITS-1:0];
    end

endmodule

// File: rtl/lfsr_stream.sv
// XNOR Fibonacci LFSR word generator behind a valid/ready stream, with seed load and lock-up flag.
// Define LFSR_LOCKUP_RECOVER_EN to replace any all-ones state with DEFAULT_SEED.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int                  NUM_BITS     = 32,
    parameter int                  STEP         = 8,
    parameter logic [NUM_BITS-1:0] DEFAULT_SEED = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                E,
    input  logic                LOAD,
    input  logic [NUM_BITS-1:0] SEED_VAL,
    lfsr_stream_if.master       out_bus,
    output logic [NUM_BITS-1:0] LFSR_VAL,
    output logic                LOCKUP
);

    localparam logic [NUM_BITS-1:0] ALL_ONES = NUM_BITS'(lfsr_ones(NUM_BITS));

    if (!lfsr_supported(NUM_BITS)) begin : g_bad_width
        $error("lfsr_stream: unsupported NUM_BITS %0d", NUM_BITS);
    end
    if ((STEP < 1) || (STEP > NUM_BITS)) begin : g_bad_step
        $error("lfsr_stream: STEP %0d outside 1..NUM_BITS", STEP);
    end
    if (DEFAULT_SEED == ALL_ONES) begin : g_bad_seed
        $error("lfsr_stream: DEFAULT_SEED is the lock-up state");
    end

    logic [NUM_BITS-1:0] state_q, state_d, leap_state, state_cand;
    logic [STEP-1:0]     word_q, word_d, leap_word;
    logic                valid_q, valid_d, lockup_q, lockup_d;
    logic                load, adv, xfer;
`ifdef LFSR_LOCKUP_RECOVER_EN
    logic                hit_ones;
`endif

    lfsr_leap #(
        .NUM_BITS (NUM_BITS),
        .STEP     (STEP)
    ) u_leap (
        .state      (state_q),
        .next_state (leap_state),
        .word       (leap_word)
    );

    always_comb begin
        load       = E & LOAD;
        adv        = E & ~LOAD & (~valid_q | out_bus.OUT_READY);
        xfer       = E & valid_q & out_bus.OUT_READY;
        state_cand = load ? SEED_VAL : leap_state;
        state_d    = state_q;
        word_d     = word_q;
        valid_d    = valid_q;
        lockup_d   = lockup_q;
`ifdef LFSR_LOCKUP_RECOVER_EN
        hit_ones = (load | adv) && (state_cand == ALL_ONES);
        if (load | adv) state_d = hit_ones ? DEFAULT_SEED : state_cand;
        if (E) lockup_d = hit_ones;
`else
        if (load | adv) state_d = state_cand;
        if (E) lockup_d = (state_q == ALL_ONES);
`endif
        // A word offered during a LOAD cycle is dropped whether or not it was taken.
        if (adv) begin
            word_d  = leap_word;
            valid_d = 1'b1;
        end else if (load | xfer) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= DEFAULT_SEED;
            word_q   <= '0;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_bus.OUT_VALID = valid_q;
    assign out_bus.OUT_WORD  = word_q;
    assign LFSR_VAL          = state_q;
    assign LOCKUP            = lockup_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: 4-bit x4, 4-bit x1 and 32-bit x8 instances on one clock.
module tb_lfsr_stream;
    import lfsr_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, E, LOAD, ready;
    logic [3:0]  seed4;
    logic [31:0] seed32;
    logic [3:0]  lfsr4, lfsr1;
    logic [31:0] lfsr32;
    logic        lock4, lock1, lock32;
    int          n_tests = 0;
    int          n_fail  = 0;

    lfsr_stream_if #(.STEP(4)) b4 ();
    lfsr_stream_if #(.STEP(1)) b1 ();
    lfsr_stream_if #(.STEP(8)) b32 ();

    assign b4.OUT_READY  = ready;
    assign b1.OUT_READY  = ready;
    assign b32.OUT_READY = ready;

    lfsr_stream #(.NUM_BITS(4), .STEP(4), .DEFAULT_SEED(4'h0)) dut4 (
        .CLK(CLK), .RESET(RESET), .E(E), .LOAD(LOAD), .SEED_VAL(seed4),
        .out_bus(b4), .LFSR_VAL(lfsr4), .LOCKUP(lock4));
    lfsr_stream #(.NUM_BITS(4), .STEP(1), .DEFAULT_SEED(4'h0)) dut1 (
        .CLK(CLK), .RESET(RESET), .E(E), .LOAD(LOAD), .SEED_VAL(seed4),
        .out_bus(b1), .LFSR_VAL(lfsr1), .LOCKUP(lock1));
    lfsr_stream #(.NUM_BITS(32), .STEP(8), .DEFAULT_SEED(32'h0)) dut32 (
        .CLK(CLK), .RESET(RESET), .E(E), .LOAD(LOAD), .SEED_VAL(seed32),
        .out_bus(b32), .LFSR_VAL(lfsr32), .LOCKUP(lock32));

    always #5 CLK = ~CLK;

    // Independent 32-bit reference: taps 32,22,2,1, XNOR feedback, MSB-first word.
    function automatic logic [39:0] model32(input logic [31:0] s);
        logic [7:0] w;
        logic       fb;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            fb = ~(s[31] ^ s[21] ^ s[1] ^ s[0]);
            w  = {w[6:0], fb};
            s  = {s[30:0], fb};
        end
        return {s, w};
    endfunction

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        @(negedge CLK);
        n_tests++;
        if (b4.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", b4.OUT_VALID); end
        n_tests++;
        if (b4.OUT_WORD !== 4'h0) begin n_fail++; $display("FAIL reset_word: got %h want 0", b4.OUT_WORD); end
        n_tests++;
        if (lfsr4 !== 4'h0) begin n_fail++; $display("FAIL reset_state: got %h want 0", lfsr4); end
        n_tests++;
        if (lock4 !== 1'b0) begin n_fail++; $display("FAIL reset_lockup: got %b want 0", lock4); end
    endtask

    task automatic test_first_words();
        E = 1'b1; LOAD = 1'b0; ready = 1'b1;
        apply_reset();
        step();
        n_tests++;
        if ({b4.OUT_VALID, b4.OUT_WORD, lfsr4} !== {1'b1, 4'b1110, 4'b1110}) begin
            n_fail++; $display("FAIL first_word: got v=%b w=%b s=%b want v=1 w=1110 s=1110", b4.OUT_VALID, b4.OUT_WORD, lfsr4);
        end
        step();
        n_tests++;
        if ({b4.OUT_VALID, b4.OUT_WORD, lfsr4} !== {1'b1, 4'b1100, 4'b1100}) begin
            n_fail++; $display("FAIL second_word: got v=%b w=%b s=%b want v=1 w=1100 s=1100", b4.OUT_VALID, b4.OUT_WORD, lfsr4);
        end
    endtask

    task automatic test_step1_period();
        logic [14:0] bits;
        logic [3:0]  st_tab [15];
        logic        b;
        logic [3:0]  s;
        bits   = 15'b111011001010000;
        st_tab = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
        E = 1'b1; LOAD = 1'b0; ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            step();
            b = bits[14 - i];
            s = st_tab[i];
            n_tests++;
            if ({b1.OUT_WORD, lfsr1} !== {b, s}) begin
                n_fail++; $display("FAIL step1_word%0d: got bit=%b s=%h want bit=%b s=%h", i, b1.OUT_WORD, lfsr1, b, s);
            end
            n_tests++;
            if (lfsr1 === 4'hF) begin n_fail++; $display("FAIL step1_ones%0d: got s=%h want not F", i, lfsr1); end
        end
        n_tests++;
        if (lock1 !== 1'b0) begin n_fail++; $display("FAIL step1_lockup: got %b want 0", lock1); end
    endtask

    task automatic test_stall();
        E = 1'b1; LOAD = 1'b0; ready = 1'b0;
        apply_reset();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if ({b4.OUT_VALID, b4.OUT_WORD, lfsr4} !== {1'b1, 4'b1110, 4'b1110}) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%b w=%b s=%b want v=1 w=1110 s=1110", i, b4.OUT_VALID, b4.OUT_WORD, lfsr4);
            end
        end
        ready = 1'b1;
        step();
        n_tests++;
        if ({b4.OUT_WORD, lfsr4} !== {4'b1100, 4'b1100}) begin
            n_fail++; $display("FAIL stall_resume: got w=%b s=%b want w=1100 s=1100", b4.OUT_WORD, lfsr4);
        end
        step();
        n_tests++;
        if ({b4.OUT_WORD, lfsr4} !== {4'b1010, 4'b1010}) begin
            n_fail++; $display("FAIL stall_next: got w=%b s=%b want w=1010 s=1010", b4.OUT_WORD, lfsr4);
        end
    endtask

    task automatic test_enable();
        E = 1'b1; LOAD = 1'b0; ready = 1'b1;
        apply_reset();
        step();
        E = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ready = i[0];
            step();
            n_tests++;
            if ({b4.OUT_VALID, b4.OUT_WORD, lfsr4} !== {1'b1, 4'b1110, 4'b1110}) begin
                n_fail++; $display("FAIL enable_freeze%0d: got v=%b w=%b s=%b want v=1 w=1110 s=1110", i, b4.OUT_VALID, b4.OUT_WORD, lfsr4);
            end
        end
        E = 1'b1; ready = 1'b1;
        step();
        n_tests++;
        if ({b4.OUT_WORD, lfsr4} !== {4'b1100, 4'b1100}) begin
            n_fail++; $display("FAIL enable_resume: got w=%b s=%b want w=1100 s=1100", b4.OUT_WORD, lfsr4);
        end
    endtask

    task automatic test_load();
        logic [39:0] m;
        E = 1'b1; LOAD = 1'b0; ready = 1'b1; seed4 = 4'h5;
        apply_reset();
        step();
        step();
        LOAD = 1'b1; seed32 = 32'h1234_5678;
        step();
        LOAD = 1'b0;
        n_tests++;
        if ({b32.OUT_VALID, lfsr32} !== {1'b0, 32'h1234_5678}) begin
            n_fail++; $display("FAIL load_cycle: got v=%b s=%h want v=0 s=12345678", b32.OUT_VALID, lfsr32);
        end
        m = model32(32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({b32.OUT_VALID, b32.OUT_WORD, lfsr32} !== {1'b1, m[7:0], m[39:8]}) begin
                n_fail++; $display("FAIL load_word%0d: got v=%b w=%h s=%h want v=1 w=%h s=%h", i, b32.OUT_VALID, b32.OUT_WORD, lfsr32, m[7:0], m[39:8]);
            end
            m = model32(m[39:8]);
        end
        n_tests++;
        if (lock32 !== 1'b0) begin n_fail++; $display("FAIL load_lockup: got %b want 0", lock32); end
    endtask

    task automatic test_lockup();
        E = 1'b1; LOAD = 1'b0; ready = 1'b1;
        apply_reset();
        step();
        LOAD = 1'b1; seed4 = 4'hF;
        step();
        LOAD = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        n_tests++;
        if ({b4.OUT_VALID, lfsr4, lock4} !== {1'b0, 4'h0, 1'b1}) begin
            n_fail++; $display("FAIL recover_load: got v=%b s=%h lock=%b want v=0 s=0 lock=1", b4.OUT_VALID, lfsr4, lock4);
        end
        step();
        n_tests++;
        if ({b4.OUT_WORD, lfsr4, lock4} !== {4'b1110, 4'b1110, 1'b0}) begin
            n_fail++; $display("FAIL recover_pulse: got w=%b s=%b lock=%b want w=1110 s=1110 lock=0", b4.OUT_WORD, lfsr4, lock4);
        end
`else
        n_tests++;
        if ({b4.OUT_VALID, lfsr4} !== {1'b0, 4'hF}) begin
            n_fail++; $display("FAIL lockup_load: got v=%b s=%h want v=0 s=f", b4.OUT_VALID, lfsr4);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({b4.OUT_VALID, b4.OUT_WORD, lfsr4} !== {1'b1, 4'hF, 4'hF}) begin
                n_fail++; $display("FAIL lockup_word%0d: got v=%b w=%h s=%h want v=1 w=f s=f", i, b4.OUT_VALID, b4.OUT_WORD, lfsr4);
            end
        end
        n_tests++;
        if (lock4 !== 1'b1) begin n_fail++; $display("FAIL lockup_flag: got %b want 1", lock4); end
        LOAD = 1'b1; seed4 = 4'h3;
        step();
        LOAD = 1'b0;
        step();
        n_tests++;
        if ({b4.OUT_WORD, lfsr4, lock4} !== {4'b1011, 4'b1011, 1'b0}) begin
            n_fail++; $display("FAIL lockup_clear: got w=%b s=%b lock=%b want w=1011 s=1011 lock=0", b4.OUT_WORD, lfsr4, lock4);
        end
`endif
    endtask

    task automatic test_reset_mid();
        E = 1'b1; LOAD = 1'b0; ready = 1'b1;
        apply_reset();
        step();
        step();
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        n_tests++;
        if ({b4.OUT_VALID, b4.OUT_WORD, lfsr4} !== {1'b0, 4'h0, 4'h0}) begin
            n_fail++; $display("FAIL reset_mid4: got v=%b w=%h s=%h want v=0 w=0 s=0", b4.OUT_VALID, b4.OUT_WORD, lfsr4);
        end
        n_tests++;
        if ({b32.OUT_VALID, b32.OUT_WORD, lfsr32} !== {1'b0, 8'h00, 32'h0}) begin
            n_fail++; $display("FAIL reset_mid32: got v=%b w=%h s=%h want v=0 w=0 s=0", b32.OUT_VALID, b32.OUT_WORD, lfsr32);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; E = 1'b1; LOAD = 1'b0; ready = 1'b1;
        seed4 = 4'h0; seed32 = 32'h0;
        test_reset();
        test_first_words();
        test_step1_period();
        test_stall();
        test_enable();
        test_load();
        test_lockup();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
